// File: rtl/run_sequencer.sv
// Run controller for the 9-bit-instruction datapath: start pulse, opcode decode, memory wait states, done/watchdog.
// Latency: CTRL_* decode is combinational from opcode in RUN; state changes take effect on the next CLK edge.
// Backpressure: ld/st stall the datapath via dp_stall for MEM_LAT-1 cycles; DONE holds until prog_ack.
//
// Ports: CLK/reset_n (async active-low); req_start, prog_ack host handshake; opcode/fcode/dp_done from
// the datapath; dp_start, dp_stall, CTRL_* strobes to the datapath; busy/prog_done/timeout status and
// cycle_count (RUN+MEMWAIT cycles of the current or last run).
module run_sequencer #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned MEM_LAT     = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 16'hFFFF
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             req_start,
    input  logic             prog_ack,
    input  logic [3:0]       opcode,
    input  logic             fcode,
    input  logic             dp_done,
    output logic             dp_start,
    output logic             dp_stall,
    output logic             CTRL_branch_rel_nz,
    output logic             CTRL_branch_rel_z,
    output logic             CTRL_branch_abs,
    output logic             CTRL_reg_write_en,
    output logic             CTRL_reg_sel,
    output logic             CTRL_lut_in,
    output logic             CTRL_mem_to_reg,
    output logic             CTRL_alu_src,
    output logic             CTRL_alu_sc_in,
    output logic             CTRL_read_mem,
    output logic             CTRL_write_mem,
    output logic [2:0]       CTRL_alu_op,
    output logic             busy,
    output logic             prog_done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int unsigned WW = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
    // Remaining MEMWAIT cycles after the first one; only meaningful when MEM_LAT > 1.
    localparam logic [WW-1:0]    WAIT_INIT = WW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [3:0] OP_ADD = 4'h0, OP_ADDI = 4'h1, OP_SUB  = 4'h2, OP_SHIFT = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4, OP_XOR  = 4'h5, OP_CMP  = 4'h6, OP_LD    = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8, OP_BRZ  = 4'h9, OP_BRNZ = 4'hA, OP_JMP   = 4'hB;
    localparam logic [3:0] OP_JMPR = 4'hC, OP_SETPC = 4'hD, OP_MOV = 4'hE;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_RUN, S_MEMWAIT, S_DONE, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
    logic             is_st_q, is_st_d;     // memory op in flight is a store (else load)
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wdog_hit;
    logic             run_phase;

    assign cycle_count = cnt_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        wait_cnt_d = wait_cnt_q;
        is_st_d    = is_st_q;
        cnt_d      = cnt_q;

        dp_start           = 1'b0;
        dp_stall           = 1'b0;
        CTRL_branch_rel_nz = 1'b0;
        CTRL_branch_rel_z  = 1'b0;
        CTRL_branch_abs    = 1'b0;
        CTRL_reg_write_en  = 1'b0;
        CTRL_reg_sel       = 1'b0;
        CTRL_lut_in        = 1'b0;
        CTRL_mem_to_reg    = 1'b0;
        CTRL_alu_src       = 1'b0;
        CTRL_alu_sc_in     = 1'b0;
        CTRL_read_mem      = 1'b0;
        CTRL_write_mem     = 1'b0;
        CTRL_alu_op        = 3'd0;
        busy               = 1'b0;
        prog_done          = 1'b0;
        timeout            = 1'b0;

        run_phase = (state_q == S_RUN) || (state_q == S_MEMWAIT);
        wdog_hit  = run_phase && (TIMEOUT_C != '0) && (cnt_q == TIMEOUT_C);

        // The watchdog-abort cycle is not counted, so the reported count stays at TIMEOUT.
        if (run_phase && !wdog_hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (req_start) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    cnt_d      = '0;
                end
            end
            S_INIT: begin
                dp_start = 1'b1;
                busy     = 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (wdog_hit) begin
                    state_d = S_ERR;
                end else if (dp_done) begin
                    state_d = S_DONE;
                end else begin
                    case (opcode)
                        OP_ADD:   begin CTRL_alu_op = 3'd0; CTRL_reg_write_en = 1'b1; end
                        OP_ADDI:  begin CTRL_alu_op = 3'd0; CTRL_alu_src = 1'b1; CTRL_reg_write_en = 1'b1; end
                        OP_SUB:   begin CTRL_alu_op = 3'd1; CTRL_reg_write_en = 1'b1; end
                        OP_SHIFT: begin
                            CTRL_alu_op       = 3'd2;
                            CTRL_alu_src      = 1'b1;
                            CTRL_alu_sc_in    = fcode;
                            CTRL_reg_write_en = 1'b1;
                        end
                        OP_AND:   begin CTRL_alu_op = 3'd3; CTRL_reg_write_en = 1'b1; end
                        OP_XOR:   begin CTRL_alu_op = 3'd4; CTRL_reg_write_en = 1'b1; end
                        OP_CMP:   CTRL_alu_op = 3'd5;
                        OP_LD, OP_ST: begin
                            if (opcode == OP_LD) begin
                                CTRL_read_mem   = 1'b1;
                                CTRL_mem_to_reg = 1'b1;
                            end
                            if (MEM_LAT > 1) begin
                                // First of MEM_LAT access cycles: stall, defer the write strobe.
                                dp_stall   = 1'b1;
                                state_d    = S_MEMWAIT;
                                wait_cnt_d = WAIT_INIT;
                                is_st_d    = (opcode == OP_ST);
                            end else begin
                                CTRL_reg_write_en = (opcode == OP_LD);
                                CTRL_write_mem    = (opcode == OP_ST);
                            end
                        end
                        OP_BRZ:   CTRL_branch_rel_z  = 1'b1;
                        OP_BRNZ:  CTRL_branch_rel_nz = 1'b1;
                        OP_JMP:   CTRL_branch_abs    = 1'b1;
                        OP_JMPR:  begin CTRL_branch_abs = 1'b1; CTRL_lut_in = 1'b1; end
                        OP_SETPC: begin CTRL_reg_sel = 1'b1; CTRL_reg_write_en = 1'b1; end
                        OP_MOV:   begin CTRL_alu_op = 3'd6; CTRL_reg_write_en = 1'b1; end
                        default:  ; // nop
                    endcase
                end
            end
            S_MEMWAIT: begin
                busy = 1'b1;
                if (wdog_hit) begin
                    state_d = S_ERR;
                end else begin
                    CTRL_read_mem   = !is_st_q;
                    CTRL_mem_to_reg = !is_st_q;
                    if (wait_cnt_q == '0) begin
                        // Final access cycle: the single write strobe of this instruction.
                        CTRL_reg_write_en = !is_st_q;
                        CTRL_write_mem    = is_st_q;
                        state_d           = S_RUN;
                    end else begin
                        dp_stall   = 1'b1;
                        wait_cnt_d = wait_cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                prog_done = 1'b1;
                if (prog_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                timeout = 1'b1;
                if (req_start) begin
                    state_d    = S_INIT;
                    init_cnt_d = '0;
                    cnt_d      = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            init_cnt_q <= '0;
            wait_cnt_q <= '0;
            is_st_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            is_st_q    <= is_st_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: random programs scored against a cycle-walking reference.
// Latency: expected outputs are produced one cycle at a time by the reference walk.
// Backpressure: n/a (bench drives all inputs).
module tb_run_sequencer;

    localparam int INIT_CYCLES = 2;
    localparam int MEM_LAT     = 3;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT     = 24;

    // Expected CTRL bundle layout: {brnz, brz, babs, we, rsel, lut, m2r, asrc, scin, rd, wr, alu_op[2:0]}
    localparam logic [13:0] BRNZ = 14'h2000, BRZ = 14'h1000, BABS = 14'h0800, WE   = 14'h0400;
    localparam logic [13:0] RSEL = 14'h0200, LUT = 14'h0100, M2R  = 14'h0080, ASRC = 14'h0040;
    localparam logic [13:0] SCIN = 14'h0020, RD  = 14'h0010, WR   = 14'h0008, NOC  = 14'h0000;

    logic [13:0] dec_tbl [16] = '{
        WE | 14'd0,             // 0 add
        ASRC | WE | 14'd0,      // 1 addi
        WE | 14'd1,             // 2 sub
        ASRC | WE | 14'd2,      // 3 shift (sc_in added from fcode)
        WE | 14'd3,             // 4 and
        WE | 14'd4,             // 5 xor
        14'd5,                  // 6 cmp
        RD | M2R | WE,          // 7 ld
        WR,                     // 8 st
        BRZ,                    // 9 brz
        BRNZ,                   // A brnz
        BABS,                   // B jmp
        BABS | LUT,             // C jmpr
        RSEL | WE,              // D setpc
        WE | 14'd6,             // E mov
        NOC                     // F nop
    };

    logic             CLK = 1'b0;
    logic             reset_n, req_start, prog_ack, fcode, dp_done;
    logic [3:0]       opcode;
    logic             dp_start, dp_stall, busy, prog_done, timeout;
    logic             CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en;
    logic             CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in;
    logic             CTRL_read_mem, CTRL_write_mem;
    logic [2:0]       CTRL_alu_op;
    logic [CNT_W-1:0] cycle_count;
    logic [18:0]      outs;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    int   oc;
    bit   from_err;
    logic wr_seen = 1'b0;
    logic mon_en  = 1'b0;

    always #5 CLK = ~CLK;

    run_sequencer #(
        .INIT_CYCLES(INIT_CYCLES), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .req_start(req_start), .prog_ack(prog_ack),
        .opcode(opcode), .fcode(fcode), .dp_done(dp_done),
        .dp_start(dp_start), .dp_stall(dp_stall),
        .CTRL_branch_rel_nz(CTRL_branch_rel_nz), .CTRL_branch_rel_z(CTRL_branch_rel_z),
        .CTRL_branch_abs(CTRL_branch_abs), .CTRL_reg_write_en(CTRL_reg_write_en),
        .CTRL_reg_sel(CTRL_reg_sel), .CTRL_lut_in(CTRL_lut_in),
        .CTRL_mem_to_reg(CTRL_mem_to_reg), .CTRL_alu_src(CTRL_alu_src),
        .CTRL_alu_sc_in(CTRL_alu_sc_in), .CTRL_read_mem(CTRL_read_mem),
        .CTRL_write_mem(CTRL_write_mem), .CTRL_alu_op(CTRL_alu_op),
        .busy(busy), .prog_done(prog_done), .timeout(timeout), .cycle_count(cycle_count)
    );

    assign outs = {dp_start, dp_stall, busy, prog_done, timeout,
                   CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs, CTRL_reg_write_en,
                   CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg, CTRL_alu_src, CTRL_alu_sc_in,
                   CTRL_read_mem, CTRL_write_mem, CTRL_alu_op};

    // Catches any write_mem pulse, including one between clock edges.
    always @(CTRL_write_mem) if (mon_en && CTRL_write_mem) wr_seen = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [18:0] ov(input logic s, input logic st, input logic b,
                                       input logic d, input logic t, input logic [13:0] c);
        return {s, st, b, d, t, c};
    endfunction

    function automatic logic [13:0] ctrl_of(input logic [3:0] op, input logic fc);
        logic [13:0] c;
        c = dec_tbl[op];
        if (op == 4'h3 && fc) c = c | SCIN;
        return c;
    endfunction

    // Entered at posedge+1 with inputs already driven; checks mid-cycle and advances one cycle.
    task automatic cycle(input string tag, input logic [18:0] e);
        #1;
        check_eq(tag, 32'(outs), 32'(e));
        check_eq("cycle_count", 32'(cycle_count), 32'(exp_cnt));
        @(posedge CLK);
        #1;
    endtask

    // One program run. mode 0: random ops, 1: opcode sweep 0..F with fcode=1, 2: random non-memory ops.
    // dp_done is raised on instruction index done_idx. outcome: 1 = finished via DONE, 2 = watchdog.
    task automatic run_prog(input int done_idx, input int mode, input bit start_from_err,
                            output int outcome);
        logic [3:0]  op;
        logic        fc;
        logic [13:0] c;
        bit          last;
        int          res;
        int          n;
        req_start = 1'b1; prog_ack = 1'b0;
        dp_done = 1'($urandom); opcode = 4'($urandom);
        cycle("start", ov(1'b0, 1'b0, 1'b0, 1'b0, start_from_err, NOC));
        exp_cnt = 0;
        for (int k = 0; k < INIT_CYCLES; k++) begin
            req_start = 1'($urandom); dp_done = 1'($urandom); opcode = 4'($urandom);
            cycle("init", ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOC));
        end
        res = 0;
        for (int i = 0; res == 0; i++) begin
            req_start = 1'($urandom); prog_ack = 1'($urandom);
            case (mode)
                1: begin op = 4'(i); fc = 1'b1; end
                2: begin
                    op = 4'($urandom);
                    if (op == 4'h7 || op == 4'h8) op = 4'hE;
                    fc = 1'($urandom);
                end
                default: begin op = 4'($urandom); fc = 1'($urandom); end
            endcase
            opcode = op; fcode = fc; c = ctrl_of(op, fc);
            if (exp_cnt == TIMEOUT) begin
                dp_done = 1'($urandom);
                cycle("watchdog", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOC));
                res = 2;
            end else if (i == done_idx) begin
                dp_done = 1'b1;
                cycle("done_detect", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOC));
                exp_cnt++;
                res = 1;
            end else if (op == 4'h7 || op == 4'h8) begin
                dp_done = 1'b0;
                for (int k = 0; k < MEM_LAT && res == 0; k++) begin
                    last = (k == MEM_LAT - 1);
                    if (k > 0) begin
                        dp_done = 1'($urandom);   // must be ignored while waiting on memory
                        req_start = 1'($urandom);
                    end
                    if (k > 0 && exp_cnt == TIMEOUT) begin
                        cycle("watchdog_mw", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NOC));
                        res = 2;
                    end else begin
                        cycle("mem_access", ov(1'b0, !last, 1'b1, 1'b0, 1'b0,
                                               last ? c : (c & ~(WE | WR))));
                        exp_cnt++;
                    end
                end
            end else begin
                dp_done = 1'b0;
                cycle("decode", ov(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c));
                exp_cnt++;
            end
        end
        req_start = 1'b0; prog_ack = 1'b0;
        if (res == 1) begin
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                req_start = 1'($urandom); dp_done = 1'($urandom);
                cycle("done_hold", ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NOC));
            end
            prog_ack = 1'b1; req_start = 1'($urandom);
            cycle("ack", ov(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NOC));
            prog_ack = 1'b0; req_start = 1'b0;
            cycle("back_idle", 19'h0);
        end else begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                prog_ack = 1'($urandom); dp_done = 1'($urandom);
                cycle("err_hold", ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NOC));
            end
            prog_ack = 1'b0;
        end
        outcome = res;
    endtask

    initial begin
        reset_n = 1'b0; req_start = 1'b0; prog_ack = 1'b0;
        opcode = 4'h0; fcode = 1'b0; dp_done = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check_eq("reset_outs", 32'(outs), 32'h0);
        check_eq("reset_cnt", 32'(cycle_count), 32'h0);
        reset_n = 1'b1;
        @(posedge CLK);
        #1;
        cycle("idle", 19'h0);

        run_prog(16, 1, 1'b0, oc);      // full opcode sweep, fcode=1
        run_prog(9, 2, 1'b0, oc);       // dp_done on the 10th run cycle -> count 10
        run_prog(1000, 0, 1'b0, oc);    // never done -> watchdog
        from_err = (oc == 2);
        for (int r = 0; r < 16; r++) begin
            run_prog($urandom_range(0, 14), $urandom_range(0, 2), from_err, oc);
            from_err = (oc == 2);
        end

        // Reset in the middle of a store's memory wait: no write strobe may ever appear.
        req_start = 1'b1; prog_ack = 1'b0; dp_done = 1'b0;
        cycle("rst_start", ov(1'b0, 1'b0, 1'b0, 1'b0, from_err, NOC));
        req_start = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < INIT_CYCLES; k++) cycle("rst_init", ov(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, NOC));
        opcode = 4'h8; wr_seen = 1'b0; mon_en = 1'b1;
        cycle("rst_st_run", ov(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, NOC));
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_async_outs", 32'(outs), 32'h0);
        check_eq("rst_async_cnt", 32'(cycle_count), 32'h0);
        exp_cnt = 0;
        @(posedge CLK);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle("rst_after", 19'h0);
        mon_en = 1'b0;
        check_eq("rst_no_write", 32'(wr_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
